// File: rtl/ppi_pkg.sv
// ---------------------------------------------------------------------------
// ppi_pkg
// Shared constants and state types for the strobed I/O port.
//   MODE_SIMPLE / MODE_STROBED : CfgMode encodings (latched I/O vs handshake)
//   DIR_IN / DIR_OUT           : CfgDir encodings (also drives PortOE)
//   in_state_t                 : strobed-input buffer state
//   out_state_t                : strobed-output handshake state
// ---------------------------------------------------------------------------
package ppi_pkg;

   localparam logic MODE_SIMPLE  = 1'b0;
   localparam logic MODE_STROBED = 1'b1;

   localparam logic DIR_IN  = 1'b0;
   localparam logic DIR_OUT = 1'b1;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } in_state_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      ACKED   = 2'd2
   } out_state_t;

endpackage

// File: rtl/strobed_io_port_if.sv
// ---------------------------------------------------------------------------
// strobed_io_port_if
// Bundles the configuration, CPU bus and peripheral pin signals of one
// strobed I/O port.
//   slave  modport : the port itself (strobed_io_port)
//   master modport : whoever drives configuration, bus and pins
// Optional macro STROBED_IO_BIT_SET_RESET_EN adds BsrWrite/BsrBit/BsrValue
// for single-bit set/clear of the output latch.
// ---------------------------------------------------------------------------
interface strobed_io_port_if #(
   parameter int WIDTH = 8
);
   localparam int BSR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // configuration
   logic             CfgWrite;
   logic             CfgMode;
   logic             CfgDir;
   logic             CfgIntEn;
   // CPU bus
   logic             BusWrite;
   logic             BusRead;
   logic [WIDTH-1:0] BusWData;
   logic [WIDTH-1:0] BusRData;
   // peripheral pins
   logic [WIDTH-1:0] PortIn;
   logic [WIDTH-1:0] PortOut;
   logic             PortOE;
   logic             Stb_n;
   logic             Ibf;
   logic             Obf_n;
   logic             Ack_n;
   logic             Intr;
   logic             Overrun;
`ifdef STROBED_IO_BIT_SET_RESET_EN
   logic             BsrWrite;
   logic [BSR_W-1:0] BsrBit;
   logic             BsrValue;

   modport slave (
      input  CfgWrite, CfgMode, CfgDir, CfgIntEn,
      input  BusWrite, BusRead, BusWData, PortIn, Stb_n, Ack_n,
      input  BsrWrite, BsrBit, BsrValue,
      output BusRData, PortOut, PortOE, Ibf, Obf_n, Intr, Overrun
   );
   modport master (
      output CfgWrite, CfgMode, CfgDir, CfgIntEn,
      output BusWrite, BusRead, BusWData, PortIn, Stb_n, Ack_n,
      output BsrWrite, BsrBit, BsrValue,
      input  BusRData, PortOut, PortOE, Ibf, Obf_n, Intr, Overrun
   );
`else
   modport slave (
      input  CfgWrite, CfgMode, CfgDir, CfgIntEn,
      input  BusWrite, BusRead, BusWData, PortIn, Stb_n, Ack_n,
      output BusRData, PortOut, PortOE, Ibf, Obf_n, Intr, Overrun
   );
   modport master (
      output CfgWrite, CfgMode, CfgDir, CfgIntEn,
      output BusWrite, BusRead, BusWData, PortIn, Stb_n, Ack_n,
      input  BusRData, PortOut, PortOE, Ibf, Obf_n, Intr, Overrun
   );
`endif

endinterface

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Synchronises an asynchronous active-low handshake line and produces
// one-cycle edge pulses.
//   Clock, Reset_n : clock, async active-low reset (chain presets to 1 = idle)
//   din            : asynchronous input
//   level          : synchronised level (last chain stage)
//   fall / rise    : one-cycle pulses, last stage vs one extra flop
// ---------------------------------------------------------------------------
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic din,
   output logic level,
   output logic fall,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_reg <= '1;
         prev_reg <= 1'b1;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   assign level = sync_reg[SYNC_STAGES-1];
   assign fall  = prev_reg & ~level;
   assign rise  = ~prev_reg & level;

endmodule

// File: rtl/strobed_io_port.sv
// ---------------------------------------------------------------------------
// strobed_io_port
// One WIDTH-bit peripheral port: mode 0 latched/sampled I/O or mode 1
// 8255-style strobed I/O (STB/IBF input, OBF/ACK output) with interrupt.
//   Clock, Reset_n : clock, async active-low reset
//   io (slave)     : config, CPU bus and pin signals (strobed_io_port_if)
// Parameters: WIDTH (1..32), SYNC_STAGES (>=2) on PortIn, Stb_n, Ack_n.
// Optional macro STROBED_IO_BIT_SET_RESET_EN enables bit set/reset of the
// output latch via BsrWrite/BsrBit/BsrValue (BusWrite wins on collision).
// ---------------------------------------------------------------------------
module strobed_io_port
   import ppi_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            Clock,
   input  logic            Reset_n,
   strobed_io_port_if.slave io
);

   // ---------------- synchronisers ----------------
   logic [WIDTH-1:0] port_sync_reg [SYNC_STAGES];
   logic             stb_level, stb_fall, stb_rise;
   logic             ack_level, ack_fall, ack_rise;
   logic             unused_levels;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) port_sync_reg[i] <= '0;
      end else begin
         port_sync_reg[0] <= io.PortIn;
         for (int i = 1; i < SYNC_STAGES; i++) port_sync_reg[i] <= port_sync_reg[i-1];
      end
   end

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_stb (
      .Clock(Clock), .Reset_n(Reset_n), .din(io.Stb_n),
      .level(stb_level), .fall(stb_fall), .rise(stb_rise)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ack (
      .Clock(Clock), .Reset_n(Reset_n), .din(io.Ack_n),
      .level(ack_level), .fall(ack_fall), .rise(ack_rise)
   );

   // only the edges drive the handshake; levels are not needed here
   assign unused_levels = stb_level ^ ack_level;

   // ---------------- state ----------------
   logic             mode_reg, mode_next;
   logic             dir_reg, dir_next;
   logic             inten_reg, inten_next;
   in_state_t        in_state_reg, in_state_next;
   out_state_t       out_state_reg, out_state_next;
   logic [WIDTH-1:0] in_latch_reg, in_latch_next;
   logic [WIDTH-1:0] out_latch_reg, out_latch_next;
   logic             intr_reg, intr_next;
   logic             overrun_reg, overrun_next;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         mode_reg      <= MODE_SIMPLE;
         dir_reg       <= DIR_IN;
         inten_reg     <= 1'b0;
         in_state_reg  <= EMPTY;
         out_state_reg <= IDLE;
         in_latch_reg  <= '0;
         out_latch_reg <= '0;
         intr_reg      <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         mode_reg      <= mode_next;
         dir_reg       <= dir_next;
         inten_reg     <= inten_next;
         in_state_reg  <= in_state_next;
         out_state_reg <= out_state_next;
         in_latch_reg  <= in_latch_next;
         out_latch_reg <= out_latch_next;
         intr_reg      <= intr_next;
         overrun_reg   <= overrun_next;
      end
   end

   always_comb begin
      mode_next      = mode_reg;
      dir_next       = dir_reg;
      inten_next     = inten_reg;
      in_state_next  = in_state_reg;
      out_state_next = out_state_reg;
      in_latch_next  = in_latch_reg;
      out_latch_next = out_latch_reg;
      intr_next      = intr_reg;
      overrun_next   = overrun_reg;

      if (io.CfgWrite) begin
         // reconfiguration aborts any handshake in progress, no interrupt
         mode_next      = io.CfgMode;
         dir_next       = io.CfgDir;
         inten_next     = io.CfgIntEn;
         in_state_next  = EMPTY;
         out_state_next = IDLE;
         in_latch_next  = '0;
         out_latch_next = '0;
         intr_next      = 1'b0;
         overrun_next   = 1'b0;
      end else if (dir_reg == DIR_OUT) begin
`ifdef STROBED_IO_BIT_SET_RESET_EN
         if (io.BsrWrite && (32'(io.BsrBit) < 32'(WIDTH)))
            out_latch_next[io.BsrBit] = io.BsrValue;
`endif
         // assigned after BSR so a same-cycle bus write wins
         if (io.BusWrite) out_latch_next = io.BusWData;
         if (mode_reg == MODE_STROBED) begin
            unique case (out_state_reg)
               IDLE: begin
                  if (io.BusWrite) begin
                     out_state_next = PENDING;
                     intr_next      = 1'b0;
                  end
               end
               PENDING: begin
                  if (!io.BusWrite && ack_fall) out_state_next = ACKED;
               end
               ACKED: begin
                  if (io.BusWrite) begin
                     out_state_next = PENDING;
                     intr_next      = 1'b0;
                  end else if (ack_rise) begin
                     out_state_next = IDLE;
                     if (inten_reg) intr_next = 1'b1;
                  end
               end
               default: out_state_next = IDLE;
            endcase
         end
      end else if (mode_reg == MODE_STROBED) begin
         unique case (in_state_reg)
            EMPTY: begin
               if (stb_fall) begin
                  in_latch_next = port_sync_reg[SYNC_STAGES-1];
                  in_state_next = FULL;
               end
            end
            FULL: begin
               if (io.BusRead) begin
                  intr_next = 1'b0;
                  // a strobe landing with the read refills the buffer
                  if (stb_fall) in_latch_next = port_sync_reg[SYNC_STAGES-1];
                  else          in_state_next = EMPTY;
               end else begin
                  if (stb_fall) overrun_next = 1'b1;
                  if (stb_rise && inten_reg) intr_next = 1'b1;
               end
            end
            default: in_state_next = EMPTY;
         endcase
      end
   end

   // ---------------- outputs ----------------
   always_comb begin
      if (dir_reg == DIR_OUT)            io.BusRData = out_latch_reg;
      else if (mode_reg == MODE_SIMPLE)  io.BusRData = port_sync_reg[SYNC_STAGES-1];
      else                               io.BusRData = in_latch_reg;
   end

   assign io.PortOut = out_latch_reg;
   assign io.PortOE  = dir_reg;
   assign io.Ibf     = (mode_reg == MODE_STROBED) && (dir_reg == DIR_IN) && (in_state_reg == FULL);
   assign io.Obf_n   = !((mode_reg == MODE_STROBED) && (dir_reg == DIR_OUT) && (out_state_reg == PENDING));
   assign io.Intr    = intr_reg;
   assign io.Overrun = overrun_reg;

endmodule

// File: doc/strobed_io_port.md
Name: strobed_io_port

Overview:
Parametrised successor to the 8-bit PPI port. It provides one WIDTH-bit peripheral port with the following modes:
- Mode 0: simple latched/sampled I/O.
- Mode 1: strobed I/O with 8255-style handshake (STB/IBF for input, OBF/ACK for output) and an interrupt request.
The bus side and the pin side are split into separate in/out/enable signals. The top level instantiates one per port group and owns the tristates.

Parameters:
WIDTH, 8, port and bus data width (1..32)
SYNC_STAGES, 2, synchroniser depth on PortIn, Stb_n, Ack_n (>=2)

Ports:
Clock  input  1  system clock, all state on rising edge
Reset_n  input  1  asynchronous, active-low reset
CfgWrite  input  1  one-cycle pulse: load CfgMode/CfgDir/CfgIntEn, reinitialise port
CfgMode  input  1  0 = mode 0, 1 = mode 1 (strobed)
CfgDir  input  1  1 = output port, 0 = input port
CfgIntEn  input  1  enables Intr generation
BusWrite  input  1  one-cycle write strobe from CPU side
BusRead  input  1  one-cycle read strobe from CPU side
BusWData  input  WIDTH  CPU write data
BusRData  output  WIDTH  CPU read data
PortIn  input  WIDTH  pin input (asynchronous)
PortOut  output  WIDTH  pin output value
PortOE  output  1  pin output enable
Stb_n  input  1  mode-1 input strobe from peripheral
Ibf  output  1  input buffer full
Obf_n  output  1  output buffer full, active low
Ack_n  input  1  mode-1 output acknowledge from peripheral
Intr  output  1  interrupt request, level
Overrun  output  1  sticky: strobe arrived while Ibf=1

Behaviour:
- Reset (Reset_n=0, async):
  - Config becomes mode 0, input, IntEn=0.
  - Data latches = 0, BusRData=0, PortOut=0, PortOE=0, Ibf=0, Obf_n=1, Intr=0, Overrun=0.
  - Synchroniser flops preset to 1 for Stb_n/Ack_n and 0 for PortIn.
- Synchronisation:
  - PortIn, Stb_n and Ack_n each pass through SYNC_STAGES flops.
  - An edge is detected from the last stage versus one extra flop, giving a one-cycle fall/rise pulse.
- CfgWrite:
  - Loads the config and clears the data latch, Ibf, Intr and Overrun; sets Obf_n=1; state -> IDLE.
  - Has priority over BusWrite, BusRead and strobe edges in the same cycle.
- PortOE = CfgDir (registered). PortOut = output latch.
- Mode 0 input: BusRData = synchronised PortIn, so latency is SYNC_STAGES cycles. BusRead has no side effect.
- Mode 0 output: BusWrite latches BusWData; PortOut updates the next cycle. BusRData = output latch (readback).
- Mode 1 input FSM, states EMPTY/FULL:
  - EMPTY + Stb fall: latch synchronised PortIn, Ibf=1 -> FULL.
  - Stb rise while FULL: Intr=1 if IntEn.
  - FULL + BusRead: Ibf=0, Intr=0 -> EMPTY.
  - FULL + Stb fall (no BusRead): Overrun=1; latch is not overwritten.
  - BusRead and Stb fall in the same cycle: new data latched, Ibf stays 1, no Overrun.
  - BusRData = input latch.
- Mode 1 output FSM, states IDLE/PENDING/ACKED:
  - BusWrite: latch data, Obf_n=0, Intr=0 -> PENDING.
  - PENDING + Ack fall: Obf_n=1 -> ACKED.
  - ACKED + Ack rise: Intr=1 if IntEn -> IDLE.
  - BusWrite while PENDING: overwrites data, Obf_n stays 0.
  - BusWrite while ACKED: treated as a new write -> PENDING, Intr=0.
- Ibf/Obf_n/Intr are held inactive in modes or directions where they do not apply.
- A mid-handshake Reset_n or CfgWrite aborts the handshake immediately with no Intr.

Optional Feature:
- Macro: STROBED_IO_BIT_SET_RESET_EN.
- With the macro defined:
  - Extra ports BsrWrite (1), BsrBit ($clog2(WIDTH)) and BsrValue (1).
  - BsrWrite sets/clears one bit of the output latch next cycle without touching handshake state.
  - BusWrite has priority if both occur in the same cycle.
  - An out-of-range BsrBit is ignored.
- Without the macro: these ports are absent and there is no BSR logic.

Decomposition:
- Package ppi_pkg holds:
  - Mode constants MODE_SIMPLE=1'b0 and MODE_STROBED=1'b1.
  - Direction constants DIR_IN/DIR_OUT.
  - Enum typedefs for the input FSM (EMPTY, FULL) and the output FSM (IDLE, PENDING, ACKED).
- Sub-module sync_edge_detect (parameter SYNC_STAGES; outputs level, fall, rise) is used for Stb_n and Ack_n. The PortIn vector uses a plain synchroniser chain.

Test Plan:
- Reset then mode 0 input, PortIn=8'hA5 -> BusRData=8'hA5 after 2 cycles; PortOE=0, Ibf=0, Obf_n=1, Intr=0.
- Mode 0 output, BusWrite 8'h3C -> PortOut=8'h3C next cycle, PortOE=1, BusRData=8'h3C.
- Mode 1 input with IntEn, PortIn=8'h5A, pulse Stb_n low 4 cycles:
  - Ibf=1 three cycles after the fall; Intr=1 after the rise.
  - BusRead returns 8'h5A, then Ibf=0 and Intr=0.
  - A second strobe before the read sets Overrun=1 and BusRData keeps the first value.
- Mode 1 output with IntEn, BusWrite 8'hC3:
  - Obf_n=0, PortOut=8'hC3.
  - Ack_n pulse -> Obf_n=1 after the fall syncs; Intr=1 after the rise syncs.
  - The next BusWrite clears Intr.
- Abort: Reset_n low while PENDING -> all outputs at reset values asynchronously. Separately, CfgWrite in the same cycle as BusWrite -> latch=0, Obf_n=1.
- With STROBED_IO_BIT_SET_RESET_EN, output latch 8'h00:
  - BSR bit 7 set -> 8'h80; BSR bit 7 clear -> 8'h00.
  - BSR together with BusWrite 8'h11 -> 8'h11.
